// File: rtl/keypad_scanner_if.sv
// Keypad pins and key-event bus shared by the scanner and the lock controller.
interface keypad_scanner_if;
  logic [3:0] row_n;
  logic [2:0] col_n;
  logic [9:0] number;
  logic       star;
  logic       sharp;
  logic       key_held;

  modport slave (
    input  row_n,
    output col_n, number, star, sharp, key_held
  );

  modport master (
    output row_n,
    input  col_n, number, star, sharp, key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x3 active-low keypad scanner: column drive, row sync, frame snapshot,
// debounce FSM and single-cycle one-hot key events.
//
//   state      | meaning
//   -----------+--------------------------------------------------
//   S_IDLE     | no key accepted, waiting for a single-key frame
//   S_DEBOUNCE | same single key seen for cnt consecutive frames
//   S_HELD     | key accepted and event fired, waiting for empty frame
//   S_RELEASE  | empty frames counted toward an accepted release
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic            clk,
  input  logic            n_rst,
  keypad_scanner_if.slave kp
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_TARGET = CW'(DEBOUNCE);

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;
  typedef enum logic [1:0] {C_EMPTY, C_SINGLE, C_MULTI} class_t;

  logic [3:0]       row_s1_q, row_s1_d;
  logic [3:0]       row_s2_q, row_s2_d;
  logic [SW-1:0]    scan_cnt_q, scan_cnt_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [2:0]       col_n_q, col_n_d;
  logic [2:0][3:0]  snap_q, snap_d;
  logic             frame_done_q, frame_done_d;
  state_t           state_q, state_d;
  logic [3:0]       key_q, key_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [9:0]       number_q, number_d;
  logic             star_q, star_d;
  logic             sharp_q, sharp_d;
  logic             key_held_q, key_held_d;

  logic             sample;
  logic [1:0]       hits;
  logic [3:0]       first_key;
  class_t           frame_class;
  logic             fire;
  logic [3:0]       fire_key;
  logic [CW-1:0]    cnt_inc;

  // Row synchroniser, scan counter, column drive and per-column snapshot.
  always_comb begin
    row_s1_d     = kp.row_n;
    row_s2_d     = row_s1_q;
    sample       = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d   = sample ? '0 : scan_cnt_q + SW'(1);
    col_idx_d    = col_idx_q;
    col_n_d      = col_n_q;
    snap_d       = snap_q;
    frame_done_d = 1'b0;
    if (sample) begin
      case (col_idx_q)
        2'd0: begin
          snap_d[0] = ~row_s2_q;
          col_idx_d = 2'd1;
          col_n_d   = 3'b101;
        end
        2'd1: begin
          snap_d[1] = ~row_s2_q;
          col_idx_d = 2'd2;
          col_n_d   = 3'b011;
        end
        default: begin
          snap_d[2]    = ~row_s2_q;
          col_idx_d    = 2'd0;
          col_n_d      = 3'b110;
          frame_done_d = 1'b1;
        end
      endcase
    end
  end

  // Classify the completed frame; key index is row*3 + col.
  always_comb begin
    hits      = 2'd0;
    first_key = 4'd0;
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (snap_q[c][r]) begin
          if (hits == 2'd0) first_key = 4'(r * 3 + c);
          if (hits != 2'd2) hits = hits + 2'd1;
        end
      end
    end
    case (hits)
      2'd0:    frame_class = C_EMPTY;
      2'd1:    frame_class = C_SINGLE;
      default: frame_class = C_MULTI;
    endcase
  end

  // Debounce FSM next state and registered event outputs.
  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    cnt_d    = cnt_q;
    fire     = 1'b0;
    fire_key = key_q;
    cnt_inc  = cnt_q + CW'(1);
    if (frame_done_q) begin
      case (state_q)
        S_IDLE: begin
          if (frame_class == C_SINGLE) begin
            key_d = first_key;
            if (DEBOUNCE == 1) begin
              fire     = 1'b1;
              fire_key = first_key;
              cnt_d    = '0;
              state_d  = S_HELD;
            end else begin
              cnt_d   = CW'(1);
              state_d = S_DEBOUNCE;
            end
          end
        end
        S_DEBOUNCE: begin
          if (frame_class == C_SINGLE && first_key == key_q) begin
            if (cnt_inc == DB_TARGET) begin
              fire    = 1'b1;
              cnt_d   = '0;
              state_d = S_HELD;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
        S_HELD: begin
          if (frame_class == C_EMPTY) begin
            if (DEBOUNCE == 1) begin
              cnt_d   = '0;
              state_d = S_IDLE;
            end else begin
              cnt_d   = CW'(1);
              state_d = S_RELEASE;
            end
          end
        end
        default: begin
          if (frame_class == C_EMPTY) begin
            if (cnt_inc == DB_TARGET) begin
              cnt_d   = '0;
              state_d = S_IDLE;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d   = '0;
            state_d = S_HELD;
          end
        end
      endcase
    end

    number_d = '0;
    star_d   = 1'b0;
    sharp_d  = 1'b0;
    if (fire) begin
      case (fire_key)
        4'd9:    star_d   = 1'b1;
        4'd10:   number_d = 10'd1;
        4'd11:   sharp_d  = 1'b1;
        default: number_d = 10'(10'd1 << (fire_key + 4'd1));
      endcase
    end
    key_held_d = (state_d == S_HELD) || (state_d == S_RELEASE);
  end

  // All state flops; rows reset to the released (pulled-up) level.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      row_s1_q     <= 4'hF;
      row_s2_q     <= 4'hF;
      scan_cnt_q   <= '0;
      col_idx_q    <= 2'd0;
      col_n_q      <= 3'b110;
      snap_q       <= '0;
      frame_done_q <= 1'b0;
      state_q      <= S_IDLE;
      key_q        <= 4'd0;
      cnt_q        <= '0;
      number_q     <= '0;
      star_q       <= 1'b0;
      sharp_q      <= 1'b0;
      key_held_q   <= 1'b0;
    end else begin
      row_s1_q     <= row_s1_d;
      row_s2_q     <= row_s2_d;
      scan_cnt_q   <= scan_cnt_d;
      col_idx_q    <= col_idx_d;
      col_n_q      <= col_n_d;
      snap_q       <= snap_d;
      frame_done_q <= frame_done_d;
      state_q      <= state_d;
      key_q        <= key_d;
      cnt_q        <= cnt_d;
      number_q     <= number_d;
      star_q       <= star_d;
      sharp_q      <= sharp_d;
      key_held_q   <= key_held_d;
    end
  end

  assign kp.col_n    = col_n_q;
  assign kp.number   = number_q;
  assign kp.star     = star_q;
  assign kp.sharp    = sharp_q;
  assign kp.key_held = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4 (12-cycle frames), DEBOUNCE=2.
module tb_keypad_scanner;

  localparam logic [11:0] K1     = 12'h001;
  localparam logic [11:0] K2     = 12'h002;
  localparam logic [11:0] K5     = 12'h010;
  localparam logic [11:0] K7     = 12'h040;
  localparam logic [11:0] K9     = 12'h100;
  localparam logic [11:0] K_STAR = 12'h200;
  localparam logic [11:0] K_0    = 12'h400;
  localparam logic [11:0] K_SH   = 12'h800;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [11:0] pressed = '0;
  logic [3:0]  row_drv;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int fd_cyc = 0;
  int pulses = 0;
  int num_pulses = 0;
  int star_pulses = 0;
  int sharp_pulses = 0;
  int hi_cycles = 0;
  int multi_hot = 0;
  int last_pulse_cyc = 0;
  logic [2:0] prev_col = 3'b110;
  logic       prev_any = 1'b0;

  keypad_scanner_if kif ();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .kp    (kif)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_drv = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && !kif.col_n[c]) row_drv[r] = 1'b0;
  end
  assign kif.row_n = row_drv;

  always @(posedge clk) cyc++;

  // Track frame boundaries (column 2 -> column 0) and event pulses.
  always @(negedge clk) begin
    if (kif.col_n == 3'b110 && prev_col == 3'b011) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    prev_col = kif.col_n;
    if (|{kif.number, kif.star, kif.sharp}) begin
      hi_cycles++;
      last_pulse_cyc = cyc;
      if ($countones({kif.number, kif.star, kif.sharp}) > 1) multi_hot++;
      if (!prev_any) begin
        pulses++;
        if (|kif.number) num_pulses++;
        if (kif.star) star_pulses++;
        if (kif.sharp) sharp_pulses++;
      end
    end
    prev_any = |{kif.number, kif.star, kif.sharp};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Returns just after the negedge of the next frame_done cycle.
  task automatic wait_fd();
    int start;
    bit seen;
    start = fd_cnt;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (fd_cnt != start) seen = 1'b1;
    end
    if (!seen) chk("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic release_all();
    wait_fd();
    pressed = '0;
    repeat (3) wait_fd();
  endtask

  initial begin
    int t0, p0, n0, s0;

    // Reset state
    repeat (3) step();
    chk("rst_col_n", kif.col_n, 3'b110);
    chk("rst_outputs", {kif.number, kif.star, kif.sharp, kif.key_held}, 13'd0);
    n_rst = 1'b1;

    // Single press of '5', exact latency and release timing
    wait_fd();
    t0 = fd_cyc;
    p0 = pulses;
    pressed = K5;
    wait_fd();
    chk("p5_no_early", pulses - p0, 0);
    wait_fd();
    step();
    chk("p5_number", kif.number, 10'h020);
    chk("p5_held_rise", kif.key_held, 1'b1);
    repeat (8) wait_fd();
    chk("p5_count", pulses - p0, 1);
    chk("p5_cycle", last_pulse_cyc, t0 + 25);
    chk("p5_width", hi_cycles, pulses);
    pressed = '0;
    wait_fd();
    chk("p5_held_release1", kif.key_held, 1'b1);
    wait_fd();
    chk("p5_held_release2", kif.key_held, 1'b1);
    step();
    chk("p5_held_fall", kif.key_held, 1'b0);

    // Bounce on '#'
    wait_fd();
    p0 = pulses;
    s0 = sharp_pulses;
    for (int i = 0; i < 6; i++) begin
      pressed = (i % 2 == 0) ? K_SH : '0;
      wait_fd();
    end
    chk("bounce_quiet", pulses - p0, 0);
    pressed = K_SH;
    wait_fd();
    wait_fd();
    step();
    chk("bounce_sharp", kif.sharp, 1'b1);
    wait_fd();
    chk("bounce_sharp_count", sharp_pulses - s0, 1);
    chk("bounce_total", pulses - p0, 1);
    pressed = '0;
    repeat (3) wait_fd();

    // Multi-key '1'+'2' rejected, then '2' released
    p0 = pulses;
    pressed = K1 | K2;
    repeat (5) wait_fd();
    chk("multi_no_event", pulses - p0, 0);
    chk("multi_not_held", kif.key_held, 1'b0);
    pressed = K1;
    wait_fd();
    chk("multi_single_early", pulses - p0, 0);
    wait_fd();
    step();
    chk("multi_then_1", kif.number, 10'h002);
    release_all();
    chk("multi_count", pulses - p0, 1);

    // Roll-over: '*' held, '0' added, '*' released
    n0 = num_pulses;
    s0 = star_pulses;
    pressed = K_STAR;
    wait_fd();
    wait_fd();
    step();
    chk("roll_star", kif.star, 1'b1);
    wait_fd();
    pressed = K_STAR | K_0;
    wait_fd();
    wait_fd();
    pressed = K_0;
    repeat (3) wait_fd();
    chk("roll_no_number", num_pulses - n0, 0);
    chk("roll_star_count", star_pulses - s0, 1);
    chk("roll_held", kif.key_held, 1'b1);
    pressed = '0;
    wait_fd();
    wait_fd();
    step();
    chk("roll_released", kif.key_held, 1'b0);
    wait_fd();
    pressed = K_0;
    wait_fd();
    wait_fd();
    step();
    chk("roll_zero", kif.number, 10'h001);
    release_all();
    chk("roll_zero_count", num_pulses - n0, 1);

    // Short release glitch during '7'
    p0 = pulses;
    pressed = K7;
    wait_fd();
    wait_fd();
    step();
    chk("glitch_seven", kif.number, 10'h080);
    wait_fd();
    pressed = '0;
    wait_fd();
    pressed = K7;
    wait_fd();
    chk("glitch_held_a", kif.key_held, 1'b1);
    wait_fd();
    wait_fd();
    chk("glitch_held_b", kif.key_held, 1'b1);
    chk("glitch_count", pulses - p0, 1);
    release_all();
    chk("glitch_released", kif.key_held, 1'b0);

    // Reset mid-debounce of '9'
    p0 = pulses;
    pressed = K9;
    wait_fd();
    repeat (5) step();
    n_rst = 1'b0;
    #1;
    chk("rst_mid_col_n", kif.col_n, 3'b110);
    chk("rst_mid_outputs", {kif.number, kif.star, kif.sharp, kif.key_held}, 13'd0);
    repeat (3) step();
    n_rst = 1'b1;
    wait_fd();
    chk("rst_mid_no_early", pulses - p0, 0);
    wait_fd();
    step();
    chk("rst_mid_nine", kif.number, 10'h200);
    wait_fd();
    wait_fd();
    chk("rst_mid_count", pulses - p0, 1);
    release_all();

    chk("onehot", multi_hot, 0);
    chk("pulse_width_all", hi_cycles, pulses);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
